if_fetch_req_ctrl: RTL and testbench

//  Pre-IF fetch controller. Sits directly upstream of the IF stage ready-go logic.

---
 rtl/if_fetch_req_ctrl_if.sv | 14 +
 rtl/if_fetch_req_ctrl.sv | 98 +++++++++
 tb/tb_if_fetch_req_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_req_ctrl_if.sv
// if_fetch_req_ctrl_if: SRAM-like instruction bus (req/addr_ok/data_ok) between fetch controller and memory.
interface if_fetch_req_ctrl_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;
  modport master (output req, wr, size, wstrb, wdata, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, wstrb, wdata, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch_req_ctrl.sv
// if_fetch_req_ctrl: pre-IF fetch controller owning the PC, one outstanding inst request, redirect-aware buffering.
module if_fetch_req_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          ADDR_W   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 fs_allowin,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    br_target,
  input  logic                 ex_flush,
  input  logic [ADDR_W-1:0]    ex_entry,
  if_fetch_req_ctrl_if.master  inst_sram,
  output logic                 fs_inst_valid,
  output logic [31:0]          fs_inst,
  output logic [ADDR_W-1:0]    fs_pc,
  output logic                 fs_adef
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inflight, pend_pc, redir_pc;
  logic discard, pend, redir, misaligned, drop;
  assign redir      = ex_flush | br_taken;
  assign redir_pc   = ex_flush ? ex_entry : br_target;
  assign misaligned = pc[1:0] != 2'b00;
  assign drop       = discard | redir;
  assign inst_sram.req   = resetn && state == S_REQ && !misaligned;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'b0;
  assign inst_sram.wdata = 32'b0;
  assign inst_sram.addr  = pc;
  assign fs_inst_valid   = state == S_HOLD;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_REQ;
    else         state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   state_nxt = misaligned ? (redir ? S_REQ : S_HOLD) : (inst_sram.addr_ok ? S_WAIT : S_REQ);
      S_WAIT:  state_nxt = inst_sram.data_ok ? (drop ? S_REQ : S_HOLD) : S_WAIT;
      S_HOLD:  state_nxt = (redir || fs_allowin) ? S_REQ : S_HOLD;
      default: state_nxt = S_REQ;
    endcase
  end
  // A redirect seen before addr_ok is parked in pend_pc so the held request is never withdrawn.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pc          <= ADDR_W'(RESET_PC);
      pc_inflight <= '0;
      pend_pc     <= '0;
      pend        <= 1'b0;
      discard     <= 1'b0;
      fs_inst     <= 32'b0;
      fs_pc       <= '0;
      fs_adef     <= 1'b0;
    end else begin
      case (state)
        S_REQ:
          if (misaligned) begin
            if (redir) pc <= redir_pc;
            else begin
              fs_inst <= 32'b0;
              fs_pc   <= pc;
              fs_adef <= 1'b1;
            end
          end else if (inst_sram.addr_ok) begin
            pc_inflight <= pc;
            pend        <= 1'b0;
            if (redir || pend) begin
              discard <= 1'b1;
              pc      <= redir ? redir_pc : pend_pc;
            end
          end else if (redir) begin
            pend_pc <= redir_pc;
            pend    <= 1'b1;
          end
        S_WAIT:
          if (inst_sram.data_ok) begin
            if (drop) begin
              discard <= 1'b0;
              if (redir) pc <= redir_pc;
            end else begin
              fs_inst <= inst_sram.rdata;
              fs_pc   <= pc_inflight;
              fs_adef <= 1'b0;
              pc      <= pc_inflight + ADDR_W'(4);
            end
          end else if (redir) begin
            discard <= 1'b1;
            pc      <= redir_pc;
          end
        S_HOLD:
          if (redir) pc <= redir_pc;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_if_fetch_req_ctrl.sv
// tb_if_fetch_req_ctrl: directed-step bench for the fetch controller with immediate-assertion checks.
module tb_if_fetch_req_ctrl;
  logic clk = 1'b0, resetn = 1'b0;
  logic fs_allowin = 1'b0, br_taken = 1'b0, ex_flush = 1'b0;
  logic [31:0] br_target = '0, ex_entry = '0;
  logic fs_inst_valid, fs_adef;
  logic [31:0] fs_inst, fs_pc;
  int total = 0, bad = 0;
  if_fetch_req_ctrl_if #(.ADDR_W(32)) bus ();
  if_fetch_req_ctrl dut (
    .clk(clk), .resetn(resetn), .fs_allowin(fs_allowin),
    .br_taken(br_taken), .br_target(br_target),
    .ex_flush(ex_flush), .ex_entry(ex_entry),
    .inst_sram(bus.master),
    .fs_inst_valid(fs_inst_valid), .fs_inst(fs_inst), .fs_pc(fs_pc), .fs_adef(fs_adef)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.addr_ok = 1'b0;
    bus.data_ok = 1'b0;
    bus.rdata   = '0;
    tick();
    chk("rst_req", 32'(bus.req), 0);
    chk("rst_valid", 32'(fs_inst_valid), 0);
    chk("rst_inst", fs_inst, 0);
    chk("rst_pc", fs_pc, 0);
    chk("rst_adef", 32'(fs_adef), 0);
    resetn = 1'b1;
    #1;
    chk("t1_req", 32'(bus.req), 1);
    chk("t1_addr", bus.addr, 32'h1c000000);
    chk("const_wr", 32'(bus.wr), 0);
    chk("const_size", 32'(bus.size), 2);
    chk("const_wstrb", 32'(bus.wstrb), 0);
    chk("const_wdata", bus.wdata, 0);
    bus.addr_ok = 1'b1;
    tick();
    chk("t1_wait_req", 32'(bus.req), 0);
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h02800000;
    tick();
    bus.data_ok = 1'b0;
    chk("t1_valid", 32'(fs_inst_valid), 1);
    chk("t1_fs_pc", fs_pc, 32'h1c000000);
    chk("t1_fs_inst", fs_inst, 32'h02800000);
    chk("t1_adef", 32'(fs_adef), 0);
    fs_allowin = 1'b1;
    tick();
    fs_allowin = 1'b0;
    chk("t1_valid_clr", 32'(fs_inst_valid), 0);
    chk("t1_next_addr", bus.addr, 32'h1c000004);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_req_held", 32'(bus.req), 1);
      chk("t2_addr_held", bus.addr, 32'h1c000004);
    end
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0;
    tick();
    chk("t2_single_req", 32'(bus.req), 0);
    bus.data_ok = 1'b1; bus.rdata = 32'haaaa0001;
    tick();
    bus.data_ok = 1'b0;
    chk("t2_fs_pc", fs_pc, 32'h1c000004);
    chk("t2_fs_inst", fs_inst, 32'haaaa0001);
    fs_allowin = 1'b1;
    tick();
    fs_allowin = 1'b0;
    chk("t2_next_addr", bus.addr, 32'h1c000008);
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0;
    chk("t3_wait_req", 32'(bus.req), 0);
    bus.data_ok = 1'b1; bus.rdata = 32'hdeadbeef;
    tick();
    bus.data_ok = 1'b0;
    chk("t3_dropped", 32'(fs_inst_valid), 0);
    chk("t3_req", 32'(bus.req), 1);
    chk("t3_addr", bus.addr, 32'h1c000100);
    br_taken = 1'b1; br_target = 32'h1c000300;
    tick();
    br_taken = 1'b0;
    chk("t4_req_kept", 32'(bus.req), 1);
    chk("t4_addr_kept", bus.addr, 32'h1c000100);
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h12345678;
    tick();
    bus.data_ok = 1'b0;
    chk("t4_dropped", 32'(fs_inst_valid), 0);
    chk("t4_addr", bus.addr, 32'h1c000300);
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h11112222;
    tick();
    bus.data_ok = 1'b0;
    chk("t5_valid", 32'(fs_inst_valid), 1);
    chk("t5_fs_pc", fs_pc, 32'h1c000300);
    ex_flush = 1'b1; ex_entry = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200; fs_allowin = 1'b1;
    tick();
    ex_flush = 1'b0; br_taken = 1'b0; fs_allowin = 1'b0;
    chk("t5_valid_clr", 32'(fs_inst_valid), 0);
    chk("t5_addr", bus.addr, 32'h1c008000);
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; br_taken = 1'b1; br_target = 32'h1c000102;
    tick();
    bus.data_ok = 1'b0; br_taken = 1'b0;
    chk("t6_no_req", 32'(bus.req), 0);
    tick();
    chk("t6_valid", 32'(fs_inst_valid), 1);
    chk("t6_adef", 32'(fs_adef), 1);
    chk("t6_fs_pc", fs_pc, 32'h1c000102);
    chk("t6_fs_inst", fs_inst, 0);
    chk("t6_still_no_req", 32'(bus.req), 0);
    ex_flush = 1'b1; ex_entry = 32'h1c000010;
    tick();
    ex_flush = 1'b0;
    chk("t6_recover_addr", bus.addr, 32'h1c000010);
    bus.addr_ok = 1'b1; ex_flush = 1'b1; ex_entry = 32'hfffffffc;
    tick();
    bus.addr_ok = 1'b0; ex_flush = 1'b0; bus.data_ok = 1'b1;
    tick();
    chk("wrap_fs_valid", 32'(fs_inst_valid), 0);
    chk("wrap_addr", bus.addr, 32'hfffffffc);
    bus.data_ok = 1'b0; bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h0badf00d;
    tick();
    bus.data_ok = 1'b0;
    chk("wrap_fs_pc", fs_pc, 32'hfffffffc);
    fs_allowin = 1'b1;
    tick();
    fs_allowin = 1'b0;
    chk("wrap_next", bus.addr, 32'h00000000);
    bus.addr_ok = 1'b1;
    tick();
    bus.addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.req), 0);
    chk("midrst_valid", 32'(fs_inst_valid), 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("midrst_addr", bus.addr, 32'h1c000000);
    chk("midrst_req_up", 32'(bus.req), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
